// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side consumer for the async FIFO, living entirely in the rclk domain.
//   Pops show-ahead words whenever the FIFO is non-empty and there is room,
//   packs PACK consecutive words into one wide beat and presents it on a
//   valid/ready master stream. A flush pulse closes a partially filled beat
//   with a keep mask and m_last. One assembly register (acc) plus one output
//   register lets popping continue while a finished beat waits for m_ready.
//
// Parameters
//   DATA_SIZE  width of one FIFO word
//   PACK       words per output beat (1..8)
//   CNT_W      width of the pop_count statistics counter
//
// Ports
//   rclk       read-domain clock, all logic on posedge
//   rrst       synchronous active-high reset
//   rEmpty     FIFO empty flag
//   rData      FIFO head word, valid whenever rEmpty==0
//   rinc       pop strobe; one word consumed per rclk edge with rinc==1
//   flush      one-cycle request to close the current partial beat
//   m_valid    output beat valid
//   m_ready    downstream accepts when m_valid && m_ready at an edge
//   m_data     packed beat, lane i = m_data[i*DATA_SIZE +: DATA_SIZE]
//   m_keep     lane-valid mask, bit i set when lane i holds a real word
//   m_last     beat was closed by a flush
//   pop_count  total words popped, wraps silently

module fifo_rd_packer #(
  parameter int DATA_SIZE = 12,
  parameter int PACK      = 2,
  parameter int CNT_W     = 16
) (
  input  logic                      rclk,
  input  logic                      rrst,
  input  logic                      rEmpty,
  input  logic [DATA_SIZE-1:0]      rData,
  output logic                      rinc,
  input  logic                      flush,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_SIZE*PACK-1:0] m_data,
  output logic [PACK-1:0]           m_keep,
  output logic                      m_last,
  output logic [CNT_W-1:0]          pop_count
);

  localparam int IDX_W  = $clog2(PACK + 1);
  localparam int BEAT_W = DATA_SIZE * PACK;
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(PACK);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // idx counts words currently held in acc (0..PACK)
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [BEAT_W-1:0] acc;
  logic [BEAT_W-1:0] acc_nxt;
  logic              flush_pend;
  logic              flush_pend_nxt;

  logic              out_free;
  logic              acc_full;
  logic              close;
  logic              pop;
  logic [IDX_W-1:0]  lane;
  logic [PACK-1:0]   keep_nxt;

  // Beat closing and pop decision. A close frees acc in the same cycle, so a
  // full acc can still accept a word when its contents move to the output
  // register at this edge; that is what sustains one word per clock.
  always_comb begin
    out_free = !m_valid || m_ready;
    acc_full = (idx == IDX_FULL);
    close    = out_free && (acc_full || (flush_pend && (idx != '0)));
    pop      = !rrst && !rEmpty && !flush_pend && (!acc_full || close);
  end

  assign rinc = pop;

  // Next assembly state. Clearing acc on close keeps unpopulated lanes of
  // the next beat at zero; a same-cycle pop then lands in lane 0.
  always_comb begin
    lane    = close ? '0 : idx;
    acc_nxt = close ? '0 : acc;
    if (pop) begin
      for (int i = 0; i < PACK; i++) begin
        if (lane == IDX_W'(i)) begin
          acc_nxt[i*DATA_SIZE +: DATA_SIZE] = rData;
        end
      end
    end

    if (pop) begin
      idx_nxt = close ? IDX_ONE : (idx + IDX_ONE);
    end else begin
      idx_nxt = close ? '0 : idx;
    end
  end

  // keep mask for a closing beat: low idx lanes set
  always_comb begin
    keep_nxt = '0;
    for (int i = 0; i < PACK; i++) begin
      keep_nxt[i] = (IDX_W'(i) < idx);
    end
  end

  // A pending flush retires either when its beat closes or, with nothing
  // buffered, on the next edge without producing a beat. Further flush
  // pulses while pending are absorbed.
  always_comb begin
    if (flush_pend) begin
      flush_pend_nxt = !(close || (idx == '0));
    end else begin
      flush_pend_nxt = flush;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      idx        <= '0;
      acc        <= '0;
      flush_pend <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_keep     <= '0;
      m_last     <= 1'b0;
      pop_count  <= '0;
    end else begin
      idx        <= idx_nxt;
      acc        <= acc_nxt;
      flush_pend <= flush_pend_nxt;

      if (pop) begin
        pop_count <= pop_count + CNT_W'(1);
      end

      // output register only loads when free, so it holds under backpressure
      if (close) begin
        m_valid <= 1'b1;
        m_data  <= acc;
        m_keep  <= keep_nxt;
        m_last  <= flush_pend;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: two instances (PACK=2/CNT_W=16 and PACK=4/CNT_W=4)
// fed from queue-based FIFO models. Beats from the PACK=2 instance are
// checked against the in-order list of popped words.

module tb_fifo_rd_packer;

  typedef struct {
    logic [47:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [11:0] w0;
    logic [11:0] w1;
    logic [23:0] data;
    logic [1:0]  keep;
    logic        last;
  } vec_t;

  logic        rclk;
  logic        rrst;

  logic        rempty2, rinc2, flush2, m_valid2, m_ready2, m_last2;
  logic [11:0] rdata2;
  logic [23:0] m_data2;
  logic [1:0]  m_keep2;
  logic [15:0] pop_count2;

  logic        rempty4, rinc4, flush4, m_valid4, m_ready4, m_last4;
  logic [11:0] rdata4;
  logic [47:0] m_data4;
  logic [3:0]  m_keep4;
  logic [3:0]  pop_count4;

  fifo_rd_packer #(.DATA_SIZE(12), .PACK(2), .CNT_W(16)) u_dut2 (
    .rclk(rclk), .rrst(rrst), .rEmpty(rempty2), .rData(rdata2), .rinc(rinc2),
    .flush(flush2), .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
    .m_keep(m_keep2), .m_last(m_last2), .pop_count(pop_count2)
  );

  fifo_rd_packer #(.DATA_SIZE(12), .PACK(4), .CNT_W(4)) u_dut4 (
    .rclk(rclk), .rrst(rrst), .rEmpty(rempty4), .rData(rdata4), .rinc(rinc4),
    .flush(flush4), .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4),
    .m_keep(m_keep4), .m_last(m_last4), .pop_count(pop_count4)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int          errors = 0;
  int          checks = 0;
  logic [11:0] fifo2[$];
  logic [11:0] fifo4[$];
  logic [11:0] popped2[$];
  beat_t       beats2[$];
  beat_t       beats4[$];
  int          pops2 = 0;
  int          pops4 = 0;
  int          viol = 0;
  bit          hide2 = 1'b0;
  logic        last_rinc2, last_rinc4;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_fifos();
    rempty2 = (fifo2.size() == 0) || hide2;
    rdata2  = (fifo2.size() != 0) ? fifo2[0] : 12'h000;
    rempty4 = (fifo4.size() == 0);
    rdata4  = (fifo4.size() != 0) ? fifo4[0] : 12'h000;
  endtask

  // Reference check of one accepted PACK=2 beat: full beats carry the next
  // two popped words; a flush-closed beat may be shorter with low-lane keep.
  task automatic sb_check2(input beat_t b);
    int          k;
    logic [1:0]  expk;
    logic [23:0] expd;
    k = b.last ? $countones(b.keep[1:0]) : 2;
    expk = (k == 2) ? 2'b11 : ((k == 1) ? 2'b01 : 2'b00);
    check("sb_keep", 64'(b.keep), 64'(expk));
    check("sb_nonempty", 64'(k == 0), 64'(0));
    expd = '0;
    for (int i = 0; i < k; i++) begin
      if (popped2.size() == 0) begin
        check("sb_underflow", 64'(popped2.size()), 64'(1));
      end else begin
        expd[i*12 +: 12] = popped2.pop_front();
      end
    end
    check("sb_data", 64'(b.data), 64'(expd));
  endtask

  task automatic cyc();
    logic  s2, s4;
    beat_t b;
    @(negedge rclk);
    s2 = rinc2;
    s4 = rinc4;
    if (rinc2 === 1'b1 && rempty2) viol++;
    if (rinc4 === 1'b1 && rempty4) viol++;
    if (m_valid2 === 1'b1 && m_ready2) begin
      b.data = {24'h0, m_data2};
      b.keep = {2'b00, m_keep2};
      b.last = m_last2;
      beats2.push_back(b);
      sb_check2(b);
    end
    if (m_valid4 === 1'b1 && m_ready4) begin
      b.data = m_data4;
      b.keep = m_keep4;
      b.last = m_last4;
      beats4.push_back(b);
    end
    @(posedge rclk);
    #1;
    last_rinc2 = s2;
    last_rinc4 = s4;
    if (s2 === 1'b1 && fifo2.size() != 0) begin
      popped2.push_back(fifo2.pop_front());
      pops2++;
    end
    if (s4 === 1'b1 && fifo4.size() != 0) begin
      void'(fifo4.pop_front());
      pops4++;
    end
    drive_fifos();
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    flush2 = 1'b0; flush4 = 1'b0;
    m_ready2 = 1'b0; m_ready4 = 1'b0;
    hide2 = 1'b0;
    fifo2.delete(); fifo4.delete();
    drive_fifos();
    repeat (2) cyc();
    rrst = 1'b0;
    popped2.delete(); beats2.delete(); beats4.delete();
    pops2 = 0; pops4 = 0;
  endtask

  task automatic wait_beats2(input int n, input int budget, input string name);
    int c = 0;
    while (beats2.size() < n && c < budget) begin cyc(); c++; end
    check(name, 64'(beats2.size() >= n), 64'(1));
  endtask

  task automatic wait_beats4(input int n, input int budget, input string name);
    int c = 0;
    while (beats4.size() < n && c < budget) begin cyc(); c++; end
    check(name, 64'(beats4.size() >= n), 64'(1));
  endtask

  task automatic wait_pops4(input int n, input int budget, input string name);
    int c = 0;
    while (pops4 < n && c < budget) begin cyc(); c++; end
    check(name, 64'(pops4 >= n), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[4];
    int          n, base, guard, pushed;
    logic [23:0] ref_data;
    bit          have_ref, stable;

    tbl[0] = '{12'h001, 12'h002, 24'h002001, 2'b11, 1'b0};
    tbl[1] = '{12'h003, 12'h004, 24'h004003, 2'b11, 1'b0};
    tbl[2] = '{12'hFFF, 12'h000, 24'h000FFF, 2'b11, 1'b0};
    tbl[3] = '{12'h800, 12'h7FF, 24'h7FF800, 2'b11, 1'b0};

    // T1: reset with a non-empty FIFO
    rrst = 1'b1;
    flush2 = 1'b0; flush4 = 1'b0; m_ready2 = 1'b0; m_ready4 = 1'b0;
    fifo2 = '{12'h111, 12'h222};
    fifo4 = '{12'h333};
    drive_fifos();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n += (last_rinc2 === 1'b1 || last_rinc4 === 1'b1) ? 1 : 0;
    end
    check("t1_rinc_in_reset", 64'(n), 64'(0));
    check("t1_m_valid", 64'(m_valid2), 64'(0));
    check("t1_m_data", 64'(m_data2), 64'(0));
    check("t1_m_keep", 64'(m_keep2), 64'(0));
    check("t1_m_last", 64'(m_last2), 64'(0));
    check("t1_pop_count", 64'(pop_count2), 64'(0));
    check("t1_dut4_outs", 64'({m_valid4, m_last4, m_keep4, pop_count4, m_data4 != 48'h0}), 64'(0));
    fifo2.delete(); fifo4.delete();
    drive_fifos();
    rrst = 1'b0;

    // T2: table-driven packing, PACK=2, m_ready=1
    for (int i = 0; i < 4; i++) begin
      fifo2.push_back(tbl[i].w0);
      fifo2.push_back(tbl[i].w1);
    end
    m_ready2 = 1'b1;
    drive_fifos();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n += (last_rinc2 === 1'b1) ? 1 : 0;
    end
    check("t2_throughput", 64'(n), 64'(4));
    wait_beats2(4, 30, "t2_timeout");
    for (int i = 0; i < 4; i++) begin
      if (i < beats2.size()) begin
        check("t2_data", 64'(beats2[i].data), 64'(tbl[i].data));
        check("t2_keep", 64'(beats2[i].keep), 64'(tbl[i].keep));
        check("t2_last", 64'(beats2[i].last), 64'(tbl[i].last));
      end
    end
    check("t2_pop_count", 64'(pop_count2), 64'(8));

    // T3: backpressure with 6 words
    do_reset();
    for (int i = 1; i <= 6; i++) fifo2.push_back(12'h100 + 12'(i));
    drive_fifos();
    n = 0; have_ref = 1'b0; stable = 1'b1; ref_data = '0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n += (last_rinc2 === 1'b1) ? 1 : 0;
      if (m_valid2 === 1'b1) begin
        if (!have_ref) begin
          ref_data = m_data2;
          have_ref = 1'b1;
        end else if (m_data2 !== ref_data) begin
          stable = 1'b0;
        end
      end
    end
    check("t3_pops_held", 64'(n), 64'(4));
    check("t3_rinc_stalled", 64'(last_rinc2), 64'(0));
    check("t3_valid_seen", 64'(have_ref), 64'(1));
    check("t3_data_stable", 64'(stable), 64'(1));
    check("t3_held_data", 64'(ref_data), 64'(24'h102101));
    m_ready2 = 1'b1;
    wait_beats2(3, 30, "t3_timeout");
    if (beats2.size() >= 3) begin
      check("t3_beat0", 64'(beats2[0].data), 64'(24'h102101));
      check("t3_beat1", 64'(beats2[1].data), 64'(24'h104103));
      check("t3_beat2", 64'(beats2[2].data), 64'(24'h106105));
    end
    check("t3_all_delivered", 64'(popped2.size() + fifo2.size()), 64'(0));

    // Reset mid-beat: partial and held data must be discarded
    do_reset();
    fifo2 = '{12'h301, 12'h302, 12'h303};
    drive_fifos();
    repeat (4) cyc();
    do_reset();
    check("rst_mid_valid", 64'(m_valid2), 64'(0));
    check("rst_mid_pop_count", 64'(pop_count2), 64'(0));

    // Full acc closed while a flush is pending: last=1, full keep
    fifo2 = '{12'h201, 12'h202, 12'h203, 12'h204};
    drive_fifos();
    repeat (6) cyc();
    flush2 = 1'b1;
    cyc();
    flush2 = 1'b0;
    m_ready2 = 1'b1;
    wait_beats2(2, 10, "ff_timeout");
    if (beats2.size() >= 2) begin
      check("ff_first_last", 64'(beats2[0].last), 64'(0));
      check("ff_data", 64'(beats2[1].data), 64'(24'h204203));
      check("ff_keep", 64'(beats2[1].keep), 64'(4'b0011));
      check("ff_last", 64'(beats2[1].last), 64'(1));
    end

    // T4: partial flush on PACK=4
    do_reset();
    m_ready4 = 1'b1;
    fifo4 = '{12'h0AA};
    drive_fifos();
    wait_pops4(1, 5, "t4_first_pop");
    flush4 = 1'b1;
    cyc();
    flush4 = 1'b0;
    fifo4.push_back(12'h0BB);
    fifo4.push_back(12'h0CC);
    drive_fifos();
    cyc();
    check("t4_no_pop_pending", 64'(last_rinc4), 64'(0));
    wait_beats4(1, 5, "t4_timeout");
    if (beats4.size() >= 1) begin
      check("t4_data", 64'(beats4[0].data), 64'(48'h0000000000AA));
      check("t4_keep", 64'(beats4[0].keep), 64'(4'b0001));
      check("t4_last", 64'(beats4[0].last), 64'(1));
    end
    wait_pops4(3, 10, "t4_more_pops");
    flush4 = 1'b1;
    cyc();
    flush4 = 1'b0;
    wait_beats4(2, 10, "t4_timeout2");
    if (beats4.size() >= 2) begin
      check("t4_data2", 64'(beats4[1].data), 64'(48'h0000000CC0BB));
      check("t4_keep2", 64'(beats4[1].keep), 64'(4'b0011));
    end

    // T6a: flush with empty acc produces no beat and does not stick
    do_reset();
    m_ready4 = 1'b1;
    flush4 = 1'b1;
    cyc();
    flush4 = 1'b0;
    repeat (3) cyc();
    check("t6_no_beat", 64'(beats4.size()), 64'(0));
    check("t6_no_valid", 64'(m_valid4), 64'(0));
    fifo4 = '{12'h055};
    drive_fifos();
    wait_pops4(1, 3, "t6_pop_after_flush");

    // T6b: pop_count wrap with CNT_W=4
    do_reset();
    m_ready4 = 1'b1;
    for (int i = 0; i < 17; i++) fifo4.push_back(12'(i));
    drive_fifos();
    wait_pops4(17, 60, "t6_wrap_pops");
    check("t6_wrap_count", 64'(pop_count4), 64'(1));

    // T5: random empty toggling, ready and flushes against scoreboard
    do_reset();
    pushed = 0; guard = 0; base = viol;
    while (pops2 < 100 && guard < 3000) begin
      if (pushed < 100 && fifo2.size() < 3) begin
        fifo2.push_back(12'($urandom));
        pushed++;
      end
      hide2 = !hide2;
      m_ready2 = 1'($urandom_range(0, 1));
      flush2 = ($urandom_range(0, 15) == 0);
      drive_fifos();
      cyc();
      guard++;
    end
    check("t5_pops", 64'(pops2), 64'(100));
    hide2 = 1'b0;
    m_ready2 = 1'b1;
    flush2 = 1'b1;
    drive_fifos();
    cyc();
    flush2 = 1'b0;
    guard = 0;
    while ((popped2.size() != 0 || m_valid2 === 1'b1) && guard < 30) begin
      cyc();
      guard++;
    end
    check("t5_drained", 64'(popped2.size()), 64'(0));
    check("t5_pop_count", 64'(pop_count2), 64'(100));
    check("t5_no_rinc_empty", 64'(viol - base), 64'(0));
    check("all_no_rinc_empty", 64'(viol), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
